gf2m_trinomial_reduce: RTL



---
 rtl/gf2m_trinomial_reduce.sv | 116 +++++++++++
 1 files changed

// File: rtl/gf2m_trinomial_reduce.sv
// gf2m_trinomial_reduce
// Reduces the 2N-1 bit carry-less product modulo x^M + x^K + 1 by folding
// the bits above M back down once per clock. The result is returned over a
// valid/ready handshake. No new operand is accepted until the current result
// has been taken.
// Build option: define GFRED_FOLDCNT_EN to expose fold_cnt, which is the
// number of folds used for the current result.
module gf2m_trinomial_reduce #(
  parameter int N        = 116,
  parameter int M        = 113,
  parameter int K        = 9,
  parameter int MAX_FOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*N-2:0]     P,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [M-1:0]       R,
  output logic               err
`ifdef GFRED_FOLDCNT_EN
  ,
  output logic [2:0]         fold_cnt
`endif
);

  localparam int PW = 2*N-1;
  localparam int CW = ($clog2(MAX_FOLD+1) > 3) ? $clog2(MAX_FOLD+1) : 3;
  localparam logic [CW-1:0] MAXF = CW'(MAX_FOLD);

  typedef enum logic [1:0] {IDLE, FOLD, DONE} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   w, w_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            err_q, err_n;

  logic [PW-1:0]   w_lo, w_hi, w_fold;
  logic [CW-1:0]   cnt_inc;
  logic            fold_clear;

  // One fold: H = W >> M, W' = W[M-1:0] ^ H ^ (H << K). Because K <= M,
  // H << K always fits in PW bits, so nothing is truncated.
  always_comb begin
    w_lo       = w & ~({PW{1'b1}} << M);
    w_hi       = w >> M;
    w_fold     = w_lo ^ w_hi ^ (w_hi << K);
    fold_clear = ((w_fold >> M) == '0);
    cnt_inc    = cnt + CW'(1);
  end

  // State, working register, fold counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      w     <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      w     <= w_n;
      cnt   <= cnt_n;
      err_q <= err_n;
    end
  end

  // Next-state logic: load in IDLE, fold until the upper bits clear or the
  // fold limit is hit, then hold the result in DONE until it is accepted.
  always_comb begin
    state_n = state;
    w_n     = w;
    cnt_n   = cnt;
    err_n   = err_q;
    case (state)
      IDLE: begin
        if (in_valid) begin
          w_n     = P;
          cnt_n   = '0;
          state_n = FOLD;
        end
      end
      FOLD: begin
        w_n   = w_fold;
        cnt_n = cnt_inc;
        if (fold_clear) begin
          state_n = DONE;
        end else if (cnt_inc == MAXF) begin
          err_n   = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs. R is forced to zero whenever no result is presented.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    R         = out_valid ? w[M-1:0] : '0;
    err       = err_q;
  end

`ifdef GFRED_FOLDCNT_EN
  // The fold count is reported only while a result is presented.
  always_comb begin
    fold_cnt = out_valid ? cnt[2:0] : 3'd0;
  end
`endif

endmodule
